// File: rtl/fread_spi_responder.sv
// SPI mode-0 flash read responder: accepts a byte offset, issues READ (0x03)
// with a 24-bit address, then streams CHUNK_BYTES bytes out as one-cycle strobes.
module fread_spi_responder #(
    parameter int unsigned CHUNK_BYTES = 2048,
    parameter int unsigned DIV         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_offset,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [15:0] CHUNK_W  = CHUNK_BYTES[15:0];
    localparam logic [7:0]  DIV_LAST = 8'(DIV - 32'd1);

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] cmd_sr_q, cmd_sr_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic        sclk_q, sclk_d;
    logic        csn_q, csn_d;
    logic        req_ready_q, req_ready_d;
    logic        pend_q, pend_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  resp_data_q, resp_data_d;
    logic        gap_cnt_q, gap_cnt_d;
    logic        phase_end_s;
    logic        unused_hi_s;

    // Upper offset byte is outside the flash's 24-bit address space.
    assign unused_hi_s = ^req_offset[31:24];
    assign phase_end_s = (div_cnt_q == DIV_LAST);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_cnt_q    <= 8'd0;
            bit_cnt_q    <= 5'd0;
            byte_cnt_q   <= 16'd0;
            cmd_sr_q     <= 32'd0;
            rx_sr_q      <= 8'd0;
            sclk_q       <= 1'b0;
            csn_q        <= 1'b1;
            req_ready_q  <= 1'b0;
            pend_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'd0;
            gap_cnt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            cmd_sr_q     <= cmd_sr_d;
            rx_sr_q      <= rx_sr_d;
            sclk_q       <= sclk_d;
            csn_q        <= csn_d;
            req_ready_q  <= req_ready_d;
            pend_q       <= pend_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        rx_sr_d    = rx_sr_q;
        sclk_d     = sclk_q;
        csn_d      = csn_q;
        pend_d     = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        // A byte assembled on the previous edge is presented one cycle later.
        resp_valid_d = pend_q;
        if (pend_q) begin
            resp_data_d = rx_sr_q;
        end else begin
            resp_data_d = resp_data_q;
        end

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                csn_d  = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d    = CMD;
                    csn_d      = 1'b0;
                    cmd_sr_d   = {8'h03, req_offset[23:0]};
                    div_cnt_d  = 8'd0;
                    bit_cnt_d  = 5'd0;
                    byte_cnt_d = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (phase_end_s) begin
                    div_cnt_d = 8'd0;
                    sclk_d    = ~sclk_q;
                    // MOSI advances only on the falling edge of spi_clk.
                    if (sclk_q) begin
                        cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
                        if (bit_cnt_q == 5'd31) begin
                            state_d   = DATA;
                            bit_cnt_d = 5'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        cmd_sr_d = cmd_sr_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (phase_end_s) begin
                    div_cnt_d = 8'd0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            pend_d     = 1'b1;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                            if ((byte_cnt_q + 16'd1) == CHUNK_W) begin
                                state_d   = GAP;
                                csn_d     = 1'b1;
                                gap_cnt_d = 1'b0;
                            end else begin
                                state_d = DATA;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        rx_sr_d = rx_sr_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            GAP: begin
                sclk_d = 1'b0;
                csn_d  = 1'b1;
                if (gap_cnt_q) begin
                    state_d   = IDLE;
                    gap_cnt_d = 1'b0;
                end else begin
                    gap_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                csn_d   = 1'b1;
            end
        endcase

        if (state_d == IDLE) begin
            req_ready_d = 1'b1;
        end else begin
            req_ready_d = 1'b0;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign spi_clk    = sclk_q;
    assign spi_cs_n   = csn_q;
    assign spi_mosi   = cmd_sr_q[31];

endmodule

// File: tb/tb_fread_spi_responder.sv
// Bench: two responders (DIV=1 and DIV=3, 4-byte chunks) share one request
// stream; each talks to its own flash model and is checked cycle by cycle.
module tb_fread_spi_responder;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [31:0] req_offset;
    logic        req_valid;
    logic [1:0]  ready_s, rvalid_s, sclk_s, csn_s, mosi_s;
    logic [7:0]  rdata_s [2];

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // expected outputs, written only by the model process
    bit         e_rdy [2], e_csn [2], e_sclk [2], e_mosi [2], e_rv [2];
    logic [7:0] e_rd [2];

    // log of observed response strobes
    logic [7:0] rlog_d [2][64];
    int         rlog_c [2][64];
    int         rlog_n [2];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [23:0] d;
        logic [7:0]  pat [4];
        pat = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        d = a - 24'h012345;
        return pat[d[1:0]] ^ d[9:2];
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", nm, g, act, exp, cyc);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned DV = (g == 0) ? 1 : 3;
        logic        miso;
        logic [23:0] alog [8];
        logic [7:0]  clog [8];
        int          an;

        fread_spi_responder #(.CHUNK_BYTES(N), .DIV(DV)) u_dut (
            .clk(clk), .reset(reset), .req_offset(req_offset), .req_valid(req_valid),
            .req_ready(ready_s[g]), .resp_data(rdata_s[g]), .resp_valid(rvalid_s[g]),
            .spi_clk(sclk_s[g]), .spi_cs_n(csn_s[g]), .spi_mosi(mosi_s[g]), .spi_miso(miso));

        // flash: decode command on rising edges, shift data out on falling edges
        initial begin
            int nb;
            int k;
            logic [31:0] sr;
            logic [23:0] fa;
            logic [7:0]  fb;
            miso = 1'b0; nb = 0; sr = 32'd0; fa = 24'd0; an = 0;
            forever begin
                @(sclk_s[g] or csn_s[g]);
                if (csn_s[g]) begin
                    nb = 0;
                end else if (sclk_s[g]) begin
                    sr = {sr[30:0], mosi_s[g]};
                    nb++;
                    if (nb == 32) begin
                        fa = sr[23:0];
                        if (an < 8) begin
                            alog[an] = fa;
                            clog[an] = sr[31:24];
                        end
                        an++;
                    end
                end else if (nb >= 32) begin
                    k = nb - 32;
                    fb = flash_byte(fa + 24'(k / 8));
                    miso = fb[7 - (k % 8)];
                end
            end
        end
    end

    // behavioural model: outputs as closed-form functions of time since handshake
    initial begin
        bit          act [2];
        bit          rdy [2];
        int          h [2];
        logic [23:0] ad [2];
        logic [7:0]  ldat [2];
        logic [31:0] cw;
        int D, EL, r, q;
        bit rdy_old;
        for (int g = 0; g < 2; g++) begin
            act[g] = 0; rdy[g] = 0; h[g] = 0; ad[g] = 24'd0; ldat[g] = 8'd0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                D  = (g == 0) ? 1 : 3;
                EL = 64 * D + 16 * D * N;
                if (reset) begin
                    act[g] = 0; rdy[g] = 0; ldat[g] = 8'd0;
                end else begin
                    rdy_old = rdy[g];
                    if (act[g] && (cyc - h[g] == EL + 2)) act[g] = 0;
                    if (!act[g] && rdy_old && req_valid) begin
                        act[g] = 1; h[g] = cyc; ad[g] = req_offset[23:0];
                    end
                    rdy[g] = !act[g];
                end
                e_rdy[g] = rdy[g];
                e_rv[g]  = 0;
                if (act[g]) begin
                    r  = cyc - h[g];
                    cw = {8'h03, ad[g]};
                    e_csn[g]  = !(r < EL);
                    e_sclk[g] = (r < EL) && ((r / D) % 2 == 1);
                    e_mosi[g] = (r < 64 * D) ? cw[31 - r / (2 * D)] : 1'b0;
                    if (r > 64 * D && ((r - 64 * D - 1) % (16 * D)) == 0) begin
                        q = (r - 64 * D - 1) / (16 * D);
                        if (q >= 1 && q <= N) begin
                            e_rv[g] = 1;
                            ldat[g] = flash_byte(ad[g] + 24'(q - 1));
                        end
                    end
                end else begin
                    e_csn[g] = 1; e_sclk[g] = 0; e_mosi[g] = 0;
                end
                e_rd[g] = ldat[g];
            end
            started = 1'b1;
        end
    end

    // compare process: every output of both instances on every falling clk edge
    initial begin
        rlog_n[0] = 0; rlog_n[1] = 0;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int g = 0; g < 2; g++) begin
                    chk("req_ready",  g, 32'(ready_s[g]),  32'(e_rdy[g]));
                    chk("spi_cs_n",   g, 32'(csn_s[g]),    32'(e_csn[g]));
                    chk("spi_clk",    g, 32'(sclk_s[g]),   32'(e_sclk[g]));
                    chk("spi_mosi",   g, 32'(mosi_s[g]),   32'(e_mosi[g]));
                    chk("resp_valid", g, 32'(rvalid_s[g]), 32'(e_rv[g]));
                    chk("resp_data",  g, 32'(rdata_s[g]),  32'(e_rd[g]));
                    if (rvalid_s[g] && rlog_n[g] < 64) begin
                        rlog_d[g][rlog_n[g]] = rdata_s[g];
                        rlog_c[g][rlog_n[g]] = cyc;
                        rlog_n[g]++;
                    end
                end
            end
        end
    end

    // directed stimulus and hand-computed literal expectations
    initial begin
        int hs, b0, b1;
        reset = 1'b1; req_valid = 1'b0; req_offset = 32'd0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("idle_ready", 0, 32'(ready_s[0]), 32'd1);
        chk("idle_ready", 1, 32'(ready_s[1]), 32'd1);
        chk("idle_csn",   0, 32'(csn_s[0]),   32'd1);
        chk("idle_rv_cnt", 0, 32'(rlog_n[0] + rlog_n[1]), 32'd0);

        // request held high through both chunks, offset changes after first accept
        hs = cyc + 1;
        req_offset = 32'hFF012345; req_valid = 1'b1;
        @(negedge clk); #1 req_offset = 32'h00000800;
        repeat (400) @(negedge clk);
        #1 req_valid = 1'b0;
        repeat (500) @(negedge clk);
        #1;
        chk("cmd_byte",  0, 32'(g_inst[0].clog[0]), 32'h03);
        chk("addr0",     0, 32'(g_inst[0].alog[0]), 32'h012345);
        chk("addr0",     1, 32'(g_inst[1].alog[0]), 32'h012345);
        chk("addr1",     0, 32'(g_inst[0].alog[1]), 32'h000800);
        chk("addr1",     1, 32'(g_inst[1].alog[1]), 32'h000800);
        chk("byte0",     0, 32'(rlog_d[0][0]), 32'hA5);
        chk("byte1",     0, 32'(rlog_d[0][1]), 32'h5A);
        chk("byte2",     0, 32'(rlog_d[0][2]), 32'hC3);
        chk("byte3",     0, 32'(rlog_d[0][3]), 32'h3C);
        chk("latency",   0, 32'(rlog_c[0][0] - hs), 32'd81);
        chk("spacing",   0, 32'(rlog_c[0][1] - rlog_c[0][0]), 32'd16);
        chk("last_byte", 0, 32'(rlog_c[0][3] - rlog_c[0][0]), 32'd48);
        chk("rehandshake", 0, 32'(rlog_c[0][4] - rlog_c[0][0]), 32'd131);
        chk("byte3",     1, 32'(rlog_d[1][3]), 32'h3C);
        chk("latency",   1, 32'(rlog_c[1][0] - hs), 32'd241);
        chk("spacing",   1, 32'(rlog_c[1][1] - rlog_c[1][0]), 32'd48);

        // reset after two bytes of the DIV=1 chunk (DIV=3 still in command phase)
        b0 = rlog_n[0]; b1 = rlog_n[1];
        hs = cyc + 1;
        req_offset = 32'h00000010; req_valid = 1'b1;
        @(negedge clk); #1 req_valid = 1'b0;
        repeat (99) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_csn",  0, 32'(csn_s[0]),  32'd1);
        chk("rst_sclk", 0, 32'(sclk_s[0]), 32'd0);
        chk("rst_csn",  1, 32'(csn_s[1]),  32'd1);
        chk("rst_sclk", 1, 32'(sclk_s[1]), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        chk("bytes_before_rst", 0, 32'(rlog_n[0] - b0), 32'd2);
        chk("bytes_before_rst", 1, 32'(rlog_n[1] - b1), 32'd0);

        // normal request after the abort
        b0 = rlog_n[0]; b1 = rlog_n[1];
        hs = cyc + 1;
        req_offset = 32'h00012345; req_valid = 1'b1;
        @(negedge clk); #1 req_valid = 1'b0;
        repeat (420) @(negedge clk);
        #1;
        chk("post_rst_n",  0, 32'(rlog_n[0] - b0), 32'd4);
        chk("post_rst_b0", 0, 32'(rlog_d[0][b0]), 32'hA5);
        chk("post_rst_b3", 0, 32'(rlog_d[0][b0 + 3]), 32'h3C);
        chk("post_rst_lat", 0, 32'(rlog_c[0][b0] - hs), 32'd81);
        chk("post_rst_n",  1, 32'(rlog_n[1] - b1), 32'd4);
        chk("post_rst_b1", 1, 32'(rlog_d[1][b1 + 1]), 32'h5A);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fread_spi_responder.md
FREAD_SPI_RESPONDER -- requirements
Module: fread_spi_responder

Interface
REQ-001 SHALL have parameter CHUNK_BYTES, default 2048: number of bytes streamed per accepted request (range 1..65535).
REQ-002 SHALL have parameter DIV, default 1: SPI clock half-period in clk cycles (range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge clocked.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_offset  input  32  byte offset of the requested chunk.
REQ-006 SHALL have port req_valid  input  1  request present; held by the initiator until accepted.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port resp_data  output  8  streamed byte.
REQ-009 SHALL have port resp_valid  output  1  one-cycle strobe qualifying resp_data; no backpressure.
REQ-010 SHALL have ports spi_clk output 1, spi_cs_n output 1, spi_mosi output 1, spi_miso input 1: SPI mode-0 flash bus.

Function
REQ-011 SHALL implement states IDLE, CMD, DATA, GAP.
REQ-012 IDLE: req_ready=1, spi_cs_n=1, spi_clk=0; a handshake is req_valid&req_ready sampled on a rising clk edge.
REQ-013 On handshake SHALL capture req_offset[23:0], ignore req_offset[31:24], drop req_ready next cycle, enter CMD.
REQ-014 CMD SHALL drive spi_cs_n=0 and shift out 32 bits MSB-first: 0x03 then the captured 24-bit address.
REQ-015 spi_mosi SHALL change only while spi_clk is low; each spi_clk phase lasts exactly DIV clk cycles.
REQ-016 The first MOSI bit SHALL be valid DIV cycles before the first spi_clk rising edge.
REQ-017 DATA SHALL sample spi_miso on the clk edge that ends each spi_clk high phase, MSB-first into an 8-bit shift register.
REQ-018 After the 8th sample of a byte, resp_valid SHALL be 1 for exactly one cycle with the assembled byte on resp_data.
REQ-019 resp_data SHALL hold its last value when resp_valid=0.
REQ-020 Byte counter SHALL be 16 bits; when it reaches CHUNK_BYTES, spi_clk SHALL stay low and the state SHALL move to GAP.
REQ-021 GAP SHALL hold spi_cs_n=1 for 2 clk cycles, then enter IDLE.
REQ-022 req_valid seen outside IDLE SHALL be ignored; no queueing.
REQ-023 With DIV=1, accept-to-first-resp_valid SHALL be 1+64+16 clk cycles and byte spacing 16 cycles.
REQ-024 Chunk total SHALL be 64+16*CHUNK_BYTES spi-clk-phase cycles with no stall between bytes.
REQ-025 A 24-bit address wrap inside a chunk SHALL be left to the flash; the block SHALL NOT split the transfer.

Reset
REQ-026 Reset asserted SHALL immediately (asynchronously) force state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, resp_valid=0, resp_data=0, counters=0.
REQ-027 req_ready SHALL be 0 during reset and 1 on the first clk edge after release.
REQ-028 Reset mid-CMD or mid-DATA SHALL abort the transfer with no further resp_valid and no partial byte emitted.

Verification
REQ-029 Reset release, req_valid=0 -> req_ready=1, spi_cs_n=1, spi_clk=0, resp_valid never 1.
REQ-030 CHUNK_BYTES=4, DIV=1, req_offset=0xFF012345 -> MOSI decodes 0x03,0x01,0x23,0x45; 32 rising edges precede the first data bit.
REQ-031 Flash model returns A5,5A,C3,3C -> exactly 4 resp_valid pulses, 16 cycles apart, carrying those bytes in order; then spi_cs_n=1 for 2 cycles, then req_ready=1.
REQ-032 req_valid held high throughout plus a new offset 0x800 -> second handshake only in IDLE after GAP; MOSI shows address 0x000800.
REQ-033 Reset pulsed after 2 bytes of a 4-byte chunk -> spi_cs_n=1 and spi_clk=0 in the same cycle; no further resp_valid; next request streams normally.
REQ-034 DIV=3 -> every spi_clk phase is 3 cycles; data still matches; byte spacing is 48 cycles.
